// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: one shared period counter, per-channel button-adjusted duty,
// double-buffered so a new duty only takes effect at the period boundary.
module pwm_multi_ch #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned CHANNELS    = 2,
   parameter int unsigned STEP        = 1,
   parameter int unsigned DUTY_RST    = 2 ** (WIDTH - 1),
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [CHANNELS-1:0]          i_inc_duty,
   input  logic [CHANNELS-1:0]          i_dec_duty,
   input  logic                         i_stagger,
   output logic [CHANNELS-1:0]          o_pwm_out,
   output logic [CHANNELS*(WIDTH+1)-1:0] o_duty,
   output logic                         o_period_stb
);

   localparam int unsigned DW      = WIDTH + 1;
   localparam int unsigned AW      = WIDTH + 2;
   localparam int unsigned PERIOD  = 1 << WIDTH;
   localparam int unsigned PH_STEP = PERIOD / CHANNELS;
   localparam int unsigned FW      = $clog2(SYNC_STAGES + 2);

   localparam logic [WIDTH-1:0] CNT_MAX   = WIDTH'(PERIOD - 1);
   localparam logic [AW-1:0]    STEP_A    = AW'(STEP);
   localparam logic [AW-1:0]    DUTY_MAX  = AW'(PERIOD);
   localparam logic [DW-1:0]    DUTY_INIT = DW'(DUTY_RST);
   localparam logic [FW-1:0]    FILL_DONE = FW'(SYNC_STAGES + 1);

   logic [WIDTH-1:0]    r_cnt;
   logic                r_period_stb;
   logic                w_wrap;

   logic [CHANNELS-1:0] r_sync_inc [SYNC_STAGES];
   logic [CHANNELS-1:0] r_sync_dec [SYNC_STAGES];
   logic [CHANNELS-1:0] r_prev_inc;
   logic [CHANNELS-1:0] r_prev_dec;
   logic [FW-1:0]       r_fill;
   logic                w_armed;
   logic [CHANNELS-1:0] w_inc_press;
   logic [CHANNELS-1:0] w_dec_press;

   assign w_wrap       = (r_cnt == CNT_MAX);
   assign o_period_stb = r_period_stb;

   // Free-running period counter; strobe lands in the cycle where the counter reads 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_period_stb <= 1'b0;
      end else begin
         r_cnt        <= r_cnt + WIDTH'(1);
         r_period_stb <= w_wrap;
      end
   end

   // Button synchronisers and previous-value flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_sync_inc[s] <= '0;
            r_sync_dec[s] <= '0;
         end
         r_prev_inc <= '0;
         r_prev_dec <= '0;
         r_fill     <= '0;
      end else begin
         r_sync_inc[0] <= i_inc_duty;
         r_sync_dec[0] <= i_dec_duty;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_sync_inc[s] <= r_sync_inc[s-1];
            r_sync_dec[s] <= r_sync_dec[s-1];
         end
         r_prev_inc <= r_sync_inc[SYNC_STAGES-1];
         r_prev_dec <= r_sync_dec[SYNC_STAGES-1];
         if (r_fill != FILL_DONE) begin
            r_fill <= r_fill + FW'(1);
         end
      end
   end

   // Edges are ignored until the chain has refilled, so a button held through reset is no press
   assign w_armed     = (r_fill == FILL_DONE);
   assign w_inc_press = {CHANNELS{w_armed}} & r_sync_inc[SYNC_STAGES-1] & ~r_prev_inc;
   assign w_dec_press = {CHANNELS{w_armed}} & r_sync_dec[SYNC_STAGES-1] & ~r_prev_dec;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic [DW-1:0]    r_pend;
      logic [DW-1:0]    r_act;
      logic             r_pwm;
      logic [AW-1:0]    w_pend_ext;
      logic [AW-1:0]    w_inc_sum;
      logic [AW-1:0]    w_inc_val;
      logic [AW-1:0]    w_dec_val;
      logic [DW-1:0]    w_pend_nxt;
      logic [WIDTH-1:0] w_ph;

      // Saturating duty arithmetic with headroom bits so neither direction can wrap
      assign w_pend_ext = AW'(r_pend);
      assign w_inc_sum  = w_pend_ext + STEP_A;
      assign w_inc_val  = (w_inc_sum > DUTY_MAX) ? DUTY_MAX : w_inc_sum;
      assign w_dec_val  = (w_pend_ext < STEP_A) ? '0 : (w_pend_ext - STEP_A);

      always_comb begin
         w_pend_nxt = r_pend;
         if (w_inc_press[k] && !w_dec_press[k]) begin
            w_pend_nxt = DW'(w_inc_val);
         end else if (w_dec_press[k] && !w_inc_press[k]) begin
            w_pend_nxt = DW'(w_dec_val);
         end
      end

      assign w_ph = r_cnt + (i_stagger ? WIDTH'(k * PH_STEP) : '0);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_pend <= DUTY_INIT;
            r_act  <= DUTY_INIT;
            r_pwm  <= 1'b0;
         end else begin
            r_pend <= w_pend_nxt;
            if (w_wrap) begin
               r_act <= r_pend;
            end
            r_pwm <= ({1'b0, w_ph} < r_act);
         end
      end

      assign o_pwm_out[k]        = r_pwm;
      assign o_duty[k*DW +: DW]  = r_act;
   end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch (WIDTH=4, CHANNELS=2, STEP=1): duty, saturation, stagger, reset.
module tb_pwm_multi_ch;

   logic       clk;
   logic       rst_n;
   logic [1:0] inc_duty;
   logic [1:0] dec_duty;
   logic       stagger;
   logic [1:0] pwm_out;
   logic [9:0] duty;
   logic       period_stb;

   int checks = 0;
   int errors = 0;

   pwm_multi_ch #(
      .WIDTH(4), .CHANNELS(2), .STEP(1), .DUTY_RST(8), .SYNC_STAGES(2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_inc_duty   (inc_duty),
      .i_dec_duty   (dec_duty),
      .i_stagger    (stagger),
      .o_pwm_out    (pwm_out),
      .o_duty       (duty),
      .o_period_stb (period_stb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Waits for a strobe, then records pwm for phases 0..15 of the following period
   task automatic measure(output logic [15:0] p0, output logic [15:0] p1, output bit ok);
      ok = 1'b0;
      p0 = '0;
      p1 = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (period_stb) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            p0[j] = pwm_out[0];
            p1[j] = pwm_out[1];
         end
      end
   endtask

   task automatic press(input int ch, input bit up);
      if (up) inc_duty[ch] = 1'b1; else dec_duty[ch] = 1'b1;
      cycles(4);
      if (up) inc_duty[ch] = 1'b0; else dec_duty[ch] = 1'b0;
      cycles(4);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycles(3);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [15:0] p0, p1;
      bit ok;
      int gap;
      rst_n = 1'b0;
      cycles(3);
      checks++;
      if (duty !== {5'd8, 5'd8} || pwm_out !== 2'b00 || period_stb !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: duty=%h pwm=%b stb=%b, required duty=108 pwm=00 stb=0",
                  duty, pwm_out, period_stb);
      end
      rst_n = 1'b1;
      gap = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         gap++;
         if (period_stb) break;
      end
      checks++;
      if (gap !== 16) begin
         errors++;
         $display("FAIL reset_first_stb: after %0d clocks, required 16", gap);
      end
      gap = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         gap++;
         if (period_stb) break;
      end
      checks++;
      if (gap !== 16) begin
         errors++;
         $display("FAIL stb_period: %0d clocks, required 16", gap);
      end
      measure(p0, p1, ok);
      checks++;
      if (!ok || p0 !== 16'h00FF || p1 !== 16'h00FF) begin
         errors++;
         $display("FAIL reset_pattern: ok=%0b p0=%h p1=%h, required 00ff 00ff", ok, p0, p1);
      end
   endtask

   task automatic test_inc_held();
      logic [15:0] p0, p1;
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (period_stb) begin ok = 1'b1; break; end
      end
      inc_duty[0] = 1'b1;
      cycles(3);
      checks++;
      if (!ok || duty[4:0] !== 5'd8) begin
         errors++;
         $display("FAIL inc_not_yet_active: ok=%0b duty0=%0d, required 8", ok, duty[4:0]);
      end
      cycles(37);
      inc_duty[0] = 1'b0;
      measure(p0, p1, ok);
      checks++;
      if (!ok || duty !== {5'd8, 5'd9} || p0 !== 16'h01FF || p1 !== 16'h00FF) begin
         errors++;
         $display("FAIL inc_held_once: duty=%h p0=%h p1=%h, required duty=109 p0=01ff p1=00ff",
                  duty, p0, p1);
      end
   endtask

   task automatic test_dec_floor();
      logic [15:0] p0, p1;
      bit ok;
      for (int i = 0; i < 9; i++) press(1, 1'b0);
      for (int r = 0; r < 2; r++) begin
         measure(p0, p1, ok);
         checks++;
         if (!ok || duty[9:5] !== 5'd0 || p1 !== 16'h0000 || p0 !== 16'h01FF) begin
            errors++;
            $display("FAIL dec_floor[%0d]: duty1=%0d p1=%h p0=%h, required 0 0000 01ff",
                     r, duty[9:5], p1, p0);
         end
      end
   endtask

   task automatic test_inc_ceiling();
      logic [15:0] p0, p1;
      bit ok;
      for (int i = 0; i < 10; i++) press(0, 1'b1);
      for (int r = 0; r < 2; r++) begin
         measure(p0, p1, ok);
         checks++;
         if (!ok || duty[4:0] !== 5'd16 || p0 !== 16'hFFFF) begin
            errors++;
            $display("FAIL inc_ceiling[%0d]: duty0=%0d p0=%h, required 16 ffff",
                     r, duty[4:0], p0);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [15:0] p0, p1;
      bit ok;
      press(0, 1'b0);
      inc_duty[0] = 1'b1;
      dec_duty[0] = 1'b1;
      cycles(4);
      inc_duty[0] = 1'b0;
      dec_duty[0] = 1'b0;
      cycles(4);
      measure(p0, p1, ok);
      checks++;
      if (!ok || duty[4:0] !== 5'd15 || p0 !== 16'h7FFF || p1 !== 16'h0000) begin
         errors++;
         $display("FAIL simultaneous: duty0=%0d p0=%h p1=%h, required 15 7fff 0000",
                  duty[4:0], p0, p1);
      end
   endtask

   task automatic test_stagger();
      logic [15:0] p0, p1;
      bit ok;
      do_reset();
      stagger = 1'b1;
      measure(p0, p1, ok);
      checks++;
      if (!ok || duty !== {5'd8, 5'd8} || p0 !== 16'h00FF || p1 !== 16'hFF00) begin
         errors++;
         $display("FAIL stagger: duty=%h p0=%h p1=%h, required 108 00ff ff00", duty, p0, p1);
      end
      stagger = 1'b0;
      measure(p0, p1, ok);
      checks++;
      if (!ok || p0 !== 16'h00FF || p1 !== 16'h00FF) begin
         errors++;
         $display("FAIL stagger_off: p0=%h p1=%h, required 00ff 00ff", p0, p1);
      end
   endtask

   task automatic test_reset_midperiod();
      logic [15:0] p0, p1;
      bit ok;
      int gap;
      for (int i = 0; i < 4; i++) press(0, 1'b1);
      measure(p0, p1, ok);
      checks++;
      if (!ok || duty[4:0] !== 5'd12 || p0 !== 16'h0FFF) begin
         errors++;
         $display("FAIL duty12: duty0=%0d p0=%h, required 12 0fff", duty[4:0], p0);
      end
      inc_duty[0] = 1'b1;
      cycles(5);
      checks++;
      if (pwm_out[0] !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_high: pwm0=%b, required 1", pwm_out[0]);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (pwm_out !== 2'b00 || duty !== {5'd8, 5'd8} || period_stb !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: pwm=%b duty=%h stb=%b, required 00 108 0",
                  pwm_out, duty, period_stb);
      end
      cycles(2);
      rst_n = 1'b1;
      gap = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         gap++;
         if (period_stb) break;
      end
      checks++;
      if (gap !== 16) begin
         errors++;
         $display("FAIL restart_cnt: first stb after %0d clocks, required 16", gap);
      end
      measure(p0, p1, ok);
      checks++;
      if (!ok || duty !== {5'd8, 5'd8} || p0 !== 16'h00FF) begin
         errors++;
         $display("FAIL held_no_press: duty=%h p0=%h, required 108 00ff", duty, p0);
      end
      inc_duty[0] = 1'b0;
      cycles(4);
      inc_duty[0] = 1'b1;
      cycles(4);
      inc_duty[0] = 1'b0;
      measure(p0, p1, ok);
      checks++;
      if (!ok || duty !== {5'd8, 5'd9} || p0 !== 16'h01FF) begin
         errors++;
         $display("FAIL repress_after_reset: duty=%h p0=%h, required 109 01ff", duty, p0);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      inc_duty = '0;
      dec_duty = '0;
      stagger  = 1'b0;
      test_reset();
      test_inc_held();
      test_dec_floor();
      test_inc_ceiling();
      test_simultaneous();
      test_stagger();
      test_reset_midperiod();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
- Parametrised multi-channel PWM generator, successor to the single-channel button-driven PWM in the TinyTapeout user slot.
- Each channel has its own duty register, adjusted by asynchronous increase/decrease buttons. Button inputs are synchronised and rising-edge detected in-block.
- All channels share one free-running period counter. Duty updates are double-buffered and take effect only at the period boundary, so outputs never glitch.
- An optional stagger mode phase-shifts channels evenly across the period.

Parameters:
- WIDTH, 4, period counter width; PWM period = 2^WIDTH clocks; duty range 0..2^WIDTH (WIDTH+1 bits).
- CHANNELS, 2, number of independent PWM channels (1..8).
- STEP, 1, duty increment/decrement per button press (1..2^WIDTH).
- DUTY_RST, 2^(WIDTH-1), duty loaded into every channel at reset (50%).
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (>=2).

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- inc_duty  in  CHANNELS  per-channel increase button, asynchronous, level.
- dec_duty  in  CHANNELS  per-channel decrease button, asynchronous, level.
- stagger  in  1  0 = all channels phase-aligned; 1 = channel k offset by k*(2^WIDTH/CHANNELS), using integer division.
- pwm_out  out  CHANNELS  PWM outputs, registered.
- duty_o  out  CHANNELS*(WIDTH+1)  active duty per channel, packed; channel k occupies bits [k*(WIDTH+1) +: WIDTH+1].
- period_stb  out  1  one-clock pulse on the cycle the counter wraps to 0.

Behaviour:

Reset (rst_n low, asynchronous):
- cnt = 0.
- Pending and active duty of every channel = DUTY_RST.
- Synchroniser and edge-detect flops = 0.
- pwm_out = 0, period_stb = 0.
- Reset deasserted mid-period restarts cleanly from cnt = 0. No button press is inferred from buttons already held high at release; the edge-detect flops reset to 0 and the synchroniser must fill first.

Counter:
- cnt increments by 1 every clock and wraps 2^WIDTH-1 -> 0.
- period_stb is registered and is high during the cycle in which cnt == 0.

Input path, per channel:
- SYNC_STAGES-flop synchroniser, then a previous-value flop.
- Press = rising edge, i.e. synced output 1 and previous-value flop 0. Exactly one press per low->high transition, regardless of how long the button is held.
- Latency: pending duty changes on clock edge SYNC_STAGES+1 after the input rises, given setup to the first edge.

Pending duty update, per channel, same clock as the detected press:
- inc press only: pending = min(pending + STEP, 2^WIDTH), saturating.
- dec press only: pending = pending - STEP, floored at 0, saturating.
- inc and dec press on the same cycle: no change.
- Arithmetic is done in WIDTH+2 bits so the saturation checks cannot wrap.

Active duty:
- active <= pending on the clock edge where cnt goes 2^WIDTH-1 -> 0.
- A press landing on that same edge updates pending only; it is applied at the following wrap.
- duty_o always reflects active, never pending.

Output, per channel:
- ph_k = (cnt + (stagger ? k*(2^WIDTH/CHANNELS) : 0)) mod 2^WIDTH.
- pwm_out[k] <= (ph_k < active_k), so the output lags cnt by one clock.
- active = 0 gives constant low; active = 2^WIDTH gives constant high. No single-cycle glitch at either extreme.
- A change to stagger takes effect on the next clock; a phase discontinuity is permitted there.

Test Plan:
1. Reset, WIDTH=4, CHANNELS=2, STEP=1, stagger=0 -> duty_o = {8,8}; each pwm_out is high 8 clocks, low 8 clocks; period_stb every 16 clocks; both channels in phase.
2. Pulse inc_duty[0] once, held high for 40 clocks -> pending duty 9 after 3 clocks; duty_o[0] becomes 9 only at the next wrap; pwm_out[0] then high 9 of 16; channel 1 unchanged.
3. Nine dec_duty[1] presses (1 high / 1 low, each level lasting 4 clocks) -> duty saturates at 0, never wraps to 16; pwm_out[1] constantly low across two full periods.
4. Drive inc_duty[0] up past 16 with 10 presses -> duty_o[0] = 16; pwm_out[0] constantly high with no low cycle at the wrap.
5. inc_duty[0] and dec_duty[0] rise in the same cycle -> duty_o[0] unchanged. stagger=1 with duty 8 -> pwm_out[1] rising edge occurs 8 clocks after pwm_out[0] rising edge.
6. Assert rst_n low mid-period with duty 12 and inc_duty held high -> outputs 0 immediately; after release duty_o = {8,8}, cnt starts at 0, and no press is counted until inc_duty goes low then high again.
